// File: rtl/decode_issue_stage_pkg.sv
// Shared encodings for the decode/issue stage: instruction field positions,
// class and condition codes, and flag bit indices.
package decode_issue_stage_pkg;

  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int CLASS_MSB = 27;
  localparam int CLASS_LSB = 26;
  localparam int L_BIT     = 20;
  localparam int RM_LSB    = 0;
  localparam int RD_LSB    = 12;
  localparam int RN_LSB    = 16;

  // Flag register layout is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    CLS_DATA   = 2'b00,
    CLS_MEM    = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_UNDEF  = 2'b11
  } inst_class_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/decode_issue_stage_cond_eval.sv
// Combinational condition-code check of a 4-bit cond field against NZCV flags.
module cond_eval
  import decode_issue_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage: decodes one instruction per cycle, evaluates its
// condition against NZCV, and stalls on register hazards tracked by a busy scoreboard.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int INST_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int PC_REG      = 15,
  parameter int FLAG_BYPASS = 1,
  localparam int REG_W      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [REG_W-1:0]  out_read_regA,
  output logic [REG_W-1:0]  out_read_regB,
  output logic [REG_W-1:0]  out_write_reg,
  output logic              out_branch,
  output logic              out_data,
  output logic              out_load,
  output logic              out_store,
  output logic              out_write_en,
  output logic              out_exec,
  output logic              out_undef,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic              flush,
  output logic [3:0]        flags
);

  // Handshake: a transfer on either side happens on a rising edge where the
  // producer's valid and the consumer's ready are both high; valid never depends on ready.

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] busy_next;

  logic [REG_W-1:0] rm, rn, rd;
  logic [3:0]       eff_flags;
  logic             cond_pass;
  logic             dec_data, dec_load, dec_store, dec_branch, dec_undef, dec_we;
  logic             use_rm, use_rn, use_rd;
  logic             dec_exec, hazard, accept;

  assign rm = in_inst[RM_LSB +: REG_W];
  assign rn = in_inst[RN_LSB +: REG_W];
  assign rd = in_inst[RD_LSB +: REG_W];

  assign eff_flags = (FLAG_BYPASS != 0 && flags_we) ? flags_in : flags;

  cond_eval u_cond_eval (
    .cond  (in_inst[COND_MSB:COND_LSB]),
    .flags (eff_flags),
    .pass  (cond_pass)
  );

  always_comb begin
    dec_data   = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    dec_undef  = 1'b0;
    dec_we     = 1'b0;
    use_rm     = 1'b0;
    use_rn     = 1'b0;
    use_rd     = 1'b0;
    case (inst_class_e'(in_inst[CLASS_MSB:CLASS_LSB]))
      CLS_DATA: begin
        dec_data = 1'b1;
        dec_we   = 1'b1;
        use_rm   = 1'b1;
        use_rn   = 1'b1;
      end
      CLS_MEM: begin
        use_rn = 1'b1;
        if (in_inst[L_BIT]) begin
          dec_load = 1'b1;
          dec_we   = 1'b1;
        end else begin
          dec_store = 1'b1;
          use_rd    = 1'b1;
        end
      end
      CLS_BRANCH: dec_branch = 1'b1;
      default:    dec_undef  = 1'b1;
    endcase
  end

  // Undefined instructions never execute, whatever their condition field says.
  assign dec_exec = cond_pass & ~dec_undef;

  // Writeback clears are visible to this cycle's hazard check.
  always_comb begin
    busy_eff = busy;
    if (wb_en) busy_eff[wb_reg] = 1'b0;
    busy_eff[PC_REG] = 1'b0;
  end

  assign hazard = (use_rm & busy_eff[rm]) |
                  (use_rn & busy_eff[rn]) |
                  ((use_rd | dec_we) & busy_eff[rd]);

  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // A set from a newly issued writer wins over a same-cycle clear of that register.
  always_comb begin
    busy_next = busy_eff;
    if (flush && out_valid && out_write_en) busy_next[out_write_reg] = 1'b0;
    if (accept && dec_exec && dec_we) busy_next[rd] = 1'b1;
    busy_next[PC_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_inst      <= '0;
      out_read_regA <= '0;
      out_read_regB <= '0;
      out_write_reg <= '0;
      out_branch    <= 1'b0;
      out_data      <= 1'b0;
      out_load      <= 1'b0;
      out_store     <= 1'b0;
      out_write_en  <= 1'b0;
      out_exec      <= 1'b0;
      out_undef     <= 1'b0;
      flags         <= '0;
      busy          <= '0;
    end else begin
      busy <= busy_next;
      if (flags_we) flags <= flags_in;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_inst      <= in_inst;
        out_read_regA <= rm;
        out_read_regB <= rn;
        out_write_reg <= rd;
        out_branch    <= dec_branch & dec_exec;
        out_data      <= dec_data;
        out_load      <= dec_load & dec_exec;
        out_store     <= dec_store & dec_exec;
        out_write_en  <= dec_we & dec_exec;
        out_exec      <= dec_exec;
        out_undef     <= dec_undef;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios plus random traffic, checked
// against an instruction-level reference model through an expected-output queue.
module tb_decode_issue_stage;

  localparam int EXP_W = 51;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, flags_we, wb_en, flush;
  logic [31:0] in_inst;
  logic [3:0]  flags_in, wb_reg;
  logic        in_ready, out_valid;
  logic [31:0] out_inst;
  logic [3:0]  out_read_regA, out_read_regB, out_write_reg, flags;
  logic        out_branch, out_data, out_load, out_store, out_write_en, out_exec, out_undef;

  decode_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_read_regA(out_read_regA), .out_read_regB(out_read_regB), .out_write_reg(out_write_reg),
    .out_branch(out_branch), .out_data(out_data), .out_load(out_load), .out_store(out_store),
    .out_write_en(out_write_en), .out_exec(out_exec), .out_undef(out_undef),
    .flags_we(flags_we), .flags_in(flags_in), .wb_en(wb_en), .wb_reg(wb_reg),
    .flush(flush), .flags(flags)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference model: architectural view of busy registers, flags and the held slot
  bit       m_busy[16];
  bit [3:0] m_flags;
  bit       m_valid;
  bit       m_held_we;
  int       m_held_rd;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cond_ok(bit [3:0] c, bit [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] model_busy_vec();
    logic [15:0] vec;
    for (int i = 0; i < 16; i++) vec[i] = m_busy[i];
    return vec;
  endfunction

  // One cycle of the reference model, evaluated with this cycle's inputs applied.
  task automatic model_step();
    bit [3:0] ef;
    bit       eb[16];
    bit [1:0] cls;
    bit [3:0] rm, rn, rd;
    bit       l, pass, hz, rdy, acc, we;
    check("busy_vec", dut.busy, model_busy_vec());
    check("flags", flags, m_flags);
    check("out_valid", out_valid, m_valid);
    ef  = flags_we ? flags_in : m_flags;
    eb  = m_busy;
    if (wb_en) eb[wb_reg] = 1'b0;
    cls = in_inst[27:26];
    rm  = in_inst[3:0];
    rn  = in_inst[19:16];
    rd  = in_inst[15:12];
    l   = in_inst[20];
    pass = cond_ok(in_inst[31:28], ef) && (cls != 2'd3);
    case (cls)
      2'd0:    hz = eb[rm] || eb[rn] || eb[rd];
      2'd1:    hz = eb[rn] || eb[rd];
      default: hz = 1'b0;
    endcase
    we  = pass && (cls == 2'd0 || (cls == 2'd1 && l));
    rdy = !flush && !hz && (!m_valid || out_ready);
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (flush && m_valid && m_held_we) eb[m_held_rd] = 1'b0;
    if (acc && we && rd != 4'd15) eb[rd] = 1'b1;
    m_busy = eb;
    if (flags_we) m_flags = flags_in;
    if (flush) m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (acc) begin
      m_held_we = we;
      m_held_rd = rd;
      exp_q.push_back({in_inst, rm, rn, rd,
                       pass && cls == 2'd2, cls == 2'd0, pass && cls == 2'd1 && l,
                       pass && cls == 2'd1 && !l, we, pass, cls == 2'd3});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(bit iv, bit [31:0] inst, bit ordy, bit fl,
                      bit fwe, bit [3:0] fin, bit wbe, bit [3:0] wbr);
    @(posedge clk);
    #1;
    in_valid = iv; in_inst = inst; out_ready = ordy; flush = fl;
    flags_we = fwe; flags_in = fin; wb_en = wbe; wb_reg = wbr;
    @(negedge clk);
    if (!reset) model_step();
  endtask

  task automatic idle(bit ordy);
    step(1'b0, 32'h0, ordy, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic retire(bit [3:0] r);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; flags_we = 1'b0; wb_en = 1'b0;
    out_ready = 1'b0; in_inst = '0; flags_in = '0; wb_reg = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    m_flags = '0; m_valid = 1'b0; m_held_we = 1'b0; m_held_rd = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_outputs",
          {out_valid, out_inst, out_read_regA, out_read_regB, out_write_reg, out_branch,
           out_data, out_load, out_store, out_write_en, out_exec, out_undef}, 64'h0);
    check("reset_flags", flags, 4'h0);
    check("reset_busy", dut.busy, 16'h0);
  endtask

  // ---------------- monitor ----------------
  logic [EXP_W-1:0] cur;
  bit seen = 1'b0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] act;
    if (reset) begin
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        act = {out_inst, out_read_regA, out_read_regB, out_write_reg, out_branch, out_data,
               out_load, out_store, out_write_en, out_exec, out_undef};
        if (!seen) begin
          if (exp_q.size() == 0) begin
            check("out_unexpected", 64'd1, 64'd0);
          end else begin
            cur = exp_q.pop_front();
            check("out_fields", 64'(act), 64'(cur));
          end
          seen = 1'b1;
        end else begin
          check("out_stable", 64'(act), 64'(cur));
        end
      end
      if (!out_valid || out_ready || flush) seen = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; flags_we = 1'b0; wb_en = 1'b0;
    out_ready = 1'b0; in_inst = '0; flags_in = '0; wb_reg = '0;
    do_reset();

    // Data inst writing R2, then a reader of R2 that waits for its writeback.
    step(1'b1, 32'hE0812003, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    idle(1'b1);
    check("first_write_reg", out_write_reg, 4'd2);
    check("first_exec_we", {out_data, out_write_en, out_exec}, 3'b111);
    check("first_busy2", dut.busy[2], 1'b1);
    step(1'b1, 32'hE0823001, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 32'hE0823001, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    check("raw_stall", in_ready, 1'b0);
    step(1'b1, 32'hE0823001, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'd2);
    check("wb_bypass_accept", in_ready, 1'b1);
    idle(1'b1);
    retire(4'd3);

    // GT under a same-cycle Z flag update fails; LE under the held Z passes.
    step(1'b1, 32'hC0834005, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 4'h0);
    step(1'b1, 32'hD0835006, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    check("gt_failed", {out_exec, out_write_en, dut.busy[4]}, 3'b000);
    idle(1'b1);
    check("le_passed", out_exec, 1'b1);

    // Load held under backpressure for three cycles, then drained.
    step(1'b1, 32'hE5912000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hE0800000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    check("load_held", {out_valid, out_load, out_write_reg}, {1'b1, 1'b1, 4'd2});
    idle(1'b1);
    idle(1'b1);

    // Held writer of R5 flushed; a reader of R5 then issues at once.
    retire(4'd5);
    step(1'b1, 32'hE0815007, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 32'hE0816005, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    check("flush_cleared", {out_valid, dut.busy[5]}, 2'b00);
    check("r5_reader_issues", in_ready, 1'b1);
    idle(1'b1);

    // Undefined class, then reset in the middle of a stall.
    step(1'b1, 32'hEC000000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    idle(1'b1);
    check("undef_flags", {out_undef, out_branch, out_data, out_load, out_store, out_write_en, out_exec},
          7'b1000000);
    step(1'b1, 32'hE0860000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 32'hE0860000, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bit [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 2) == 0) inst[31:28] = 4'hE;
      step($urandom_range(0, 3) != 0, inst, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Registered decode/issue stage between fetch and execute.
- Decodes one 32-bit instruction per cycle into register indices and class enables.
- Holds the architectural NZCV flag register and evaluates the condition field against it.
- Tracks pending register writes in a scoreboard and stalls on hazards; ready/valid handshakes on both sides, plus flush.

Parameters:
- INST_W, 32, instruction width.
- NUM_REGS, 16, architectural register count; index width REG_W = $clog2(NUM_REGS).
- PC_REG, 15, register index that never causes a hazard and is never marked busy.
- FLAG_BYPASS, 1, when 1 a same-cycle flags_we value is used for condition evaluation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_inst  in  INST_W  instruction word
- in_ready  out  1  stage accepts in_inst this cycle
- out_valid  out  1  decoded instruction held for execute
- out_ready  in  1  execute consumes the held instruction
- out_inst  out  INST_W  held instruction word
- out_read_regA / out_read_regB / out_write_reg  out  REG_W each  Rm [3:0], Rn [19:16], Rd [15:12]
- out_branch / out_data / out_load / out_store / out_write_en / out_exec / out_undef  out  1 each  class and enable flags
- flags_we  in  1  execute updates flags
- flags_in  in  4  new {N,Z,C,V}
- wb_en  in  1  writeback retires a register write
- wb_reg  in  REG_W  register retired
- flush  in  1  kill the held instruction
- flags  out  4  current flag register

Behaviour:
- Reset (synchronous, active-high): out_valid=0, all out_* fields=0, flags=0, scoreboard=0.
- Field layout:
  - cond [31:28]; class [27:26]: 00 data, 01 load/store, 10 branch, 11 undefined; L bit [20].
  - Data: out_data=1, out_write_en=1.
  - Load/store: L=1 gives load (out_load=1, out_write_en=1); L=0 gives store (out_store=1, out_write_en=0).
  - Branch: out_branch=1, out_write_en=0.
  - Undefined: out_undef=1, all enables 0.
- Condition evaluation:
  - Uses the effective flags: flags_in when FLAG_BYPASS=1 and flags_we=1, otherwise the flags register.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.
- Failed condition: the instruction is still issued with out_exec=0. out_write_en/out_load/out_store/out_branch are forced to 0, and no scoreboard bit is set.
- Flag register: loads flags_in on any cycle with flags_we=1; otherwise holds.
- Scoreboard:
  - One busy bit per register; busy[PC_REG] is always 0.
  - Clears are applied first: the effective busy vector is busy with wb_reg cleared when wb_en=1.
  - Hazard = a used source is busy in the effective vector (RAW), or Rd is busy when write_en is set (WAW).
  - Sources used: data reads Rm and Rn; load reads Rn; store reads Rn and Rd; branch reads none.
  - On accept with exec & write_en, busy[Rd] is set; a set wins over a same-cycle clear of the same register.
- Handshake:
  - in_ready = !flush & !hazard & (!out_valid | out_ready).
  - Accept when in_valid & in_ready: the output register loads next cycle, so latency is 1 cycle.
  - If out_ready and nothing accepted, out_valid falls to 0.
  - out_* fields are stable while out_valid & !out_ready.
- Flush:
  - Next cycle out_valid=0.
  - If the held instruction had exec & write_en, its busy[out_write_reg] is cleared.
  - Nothing is accepted in the flush cycle.
  - wb_en and flags_we are still honoured during flush.
- Hazard with in_valid=1: nothing is accepted; the held instruction drains normally.

Decomposition:
- Shared package holds:
  - Field bit positions, the class codes (00/01/10/11) and the 16 condition codes.
  - NZCV bit indices.
- Sub-module cond_eval (combinational: cond, flags → pass) is natural and reusable by execute.

Test Plan:
- After reset, data inst 0xE0812003 (AL, Rd=2), out_ready=1 → next cycle out_data=1, out_write_en=1, out_write_reg=2, out_exec=1; busy[2]=1.
- Then 0xE0823001 (reads Rn=2, Rm=1) → in_ready=0 until wb_en=1, wb_reg=2. Accept happens in that same cycle (bypass), so it issues 1 cycle later.
- flags_we=1, flags_in=0100 (Z) in the same cycle as a GT-conditioned data inst → out_exec=0, out_write_en=0, no busy bit set. LE under the same flags → out_exec=1.
- Load 0xE5912000 with out_ready=0 for 3 cycles → out_valid held, fields stable, in_ready=0. Raising out_ready drains it; out_load=1, out_write_reg=2.
- Held data inst writing R5, flush=1 → next cycle out_valid=0, busy[5]=0. A new inst reading R5 then issues with no stall.
- Class 11 instruction → out_undef=1, all enables 0, scoreboard unchanged. Reset asserted mid-stall → all outputs and busy bits 0 the next cycle.
